sspm_backbone: RTL

Parametrised shared scratchpad memory (SSPM) backbone for N cores. Each core attaches through its own OCP core port. A time-division-multiplexed (TDM) slot counter grants exactly one core per cycle access to a single shared, byte-writable memory. Replaces the fixed three-connector, passthrough-plus-select arrangement with real request latching, arbitration, storage and OCP responses.

---
 rtl/sspm_pkg.sv | 13 +
 rtl/sspm_if.sv | 21 ++
 rtl/sspm_connector.sv | 68 ++++++
 rtl/sspm_backbone.sv | 75 +++++++
 4 files changed

// File: rtl/sspm_pkg.sv
// sspm_pkg: shared OCP encodings and sizing helper for the scratchpad backbone
package sspm_pkg;
  localparam logic [2:0] OCP_CMD_IDLE = 3'd0;
  localparam logic [2:0] OCP_CMD_WR = 3'd1;
  localparam logic [2:0] OCP_CMD_RD = 3'd2;
  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA = 2'd1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sspm_if.sv
// sspm_if: flattened OCP core ports, core i occupies slice i of every vector
interface sspm_if #(
  parameter int NCORES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic [3*NCORES-1:0] io_ocp_M_Cmd;
  logic [ADDR_W*NCORES-1:0] io_ocp_M_Addr;
  logic [DATA_W*NCORES-1:0] io_ocp_M_Data;
  logic [(DATA_W/8)*NCORES-1:0] io_ocp_M_ByteEn;
  logic [2*NCORES-1:0] io_ocp_S_Resp;
  logic [DATA_W*NCORES-1:0] io_ocp_S_Data;
  modport master (
    output io_ocp_M_Cmd, io_ocp_M_Addr, io_ocp_M_Data, io_ocp_M_ByteEn,
    input io_ocp_S_Resp, io_ocp_S_Data
  );
  modport slave (
    input io_ocp_M_Cmd, io_ocp_M_Addr, io_ocp_M_Data, io_ocp_M_ByteEn,
    output io_ocp_S_Resp, io_ocp_S_Data
  );
endinterface

// File: rtl/sspm_connector.sv
// sspm_connector: per-core request latch, pending flag and one-cycle OCP response
module sspm_connector import sspm_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IW = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [2:0] cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic grant_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic pending_o,
  output logic wr_o,
  output logic [IW-1:0] idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [1:0] resp_o,
  output logic [DATA_W-1:0] sdata_o
);
  logic pending_q, pending_d, wr_q, wr_d, resp_q, resp_d, rd_q, rd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic valid, accept;
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:IW+2], addr_i[1:0]};
  assign valid = cmd_i == OCP_CMD_WR || cmd_i == OCP_CMD_RD;
  // commands arriving while a request is pending are dropped on the floor
  assign accept = !pending_q && valid;
  always_comb begin
    pending_d = pending_q ? !grant_i : valid;
    wr_d = accept ? cmd_i == OCP_CMD_WR : wr_q;
    idx_d = accept ? addr_i[IW+1:2] : idx_q;
    data_d = accept ? data_i : data_q;
    be_d = accept ? be_i : be_q;
    resp_d = grant_i && pending_q;
    rd_d = grant_i && pending_q && !wr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      wr_q <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
      be_q <= '0;
      resp_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      data_q <= data_d;
      be_q <= be_d;
      resp_q <= resp_d;
      rd_q <= rd_d;
    end
  end
  assign pending_o = pending_q;
  assign wr_o = wr_q;
  assign idx_o = idx_q;
  assign data_o = data_q;
  assign be_o = be_q;
  assign resp_o = resp_q ? OCP_RESP_DVA : OCP_RESP_NULL;
  assign sdata_o = (resp_q && rd_q) ? rdata_i : '0;
endmodule

// File: rtl/sspm_backbone.sv
// sspm_backbone: TDM-arbitrated shared byte-writable scratchpad for NCORES OCP cores
module sspm_backbone import sspm_pkg::*; #(
  parameter int NCORES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_WORDS = 1024,
  localparam int SW = NCORES > 1 ? clog2(NCORES) : 1,
  localparam int NB = DATA_W / 8,
  localparam int IW = clog2(MEM_WORDS)
) (
  input  logic clk,
  input  logic reset,
  sspm_if.slave ocp,
  output logic [SW-1:0] io_slot
);
  logic [SW-1:0] slot_q, slot_d;
  logic [NCORES-1:0] pending, wr, grant;
  logic [IW-1:0] idx [NCORES];
  logic [DATA_W-1:0] data [NCORES];
  logic [NB-1:0] be [NCORES];
  logic gnt_any, sel_wr;
  logic [IW-1:0] sel_idx;
  logic [DATA_W-1:0] sel_data, rdata_q;
  logic [NB-1:0] sel_be;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  assign slot_d = (NCORES == 1 || slot_q == SW'(NCORES - 1)) ? '0 : slot_q + SW'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else slot_q <= slot_d;
  end
  assign io_slot = slot_q;
  for (genvar i = 0; i < NCORES; i++) begin : g_conn
    assign grant[i] = pending[i] && slot_q == SW'(i);
    sspm_connector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IW(IW)) u_conn (
      .clk(clk),
      .rst_n(reset),
      .cmd_i(ocp.io_ocp_M_Cmd[3*i +: 3]),
      .addr_i(ocp.io_ocp_M_Addr[ADDR_W*i +: ADDR_W]),
      .data_i(ocp.io_ocp_M_Data[DATA_W*i +: DATA_W]),
      .be_i(ocp.io_ocp_M_ByteEn[NB*i +: NB]),
      .grant_i(grant[i]),
      .rdata_i(rdata_q),
      .pending_o(pending[i]),
      .wr_o(wr[i]),
      .idx_o(idx[i]),
      .data_o(data[i]),
      .be_o(be[i]),
      .resp_o(ocp.io_ocp_S_Resp[2*i +: 2]),
      .sdata_o(ocp.io_ocp_S_Data[DATA_W*i +: DATA_W])
    );
  end
  // the slot decode guarantees at most one grant, so a priority-free mux suffices
  always_comb begin
    gnt_any = |grant;
    sel_wr = 1'b0;
    sel_idx = '0;
    sel_data = '0;
    sel_be = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (grant[k]) begin
        sel_wr = wr[k];
        sel_idx = idx[k];
        sel_data = data[k];
        sel_be = be[k];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      rdata_q <= mem_q[sel_idx];
      for (int b = 0; b < NB; b++)
        if (sel_wr && sel_be[b]) mem_q[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
    end
  end
endmodule
